ch446q_matrix_rx: RTL and testbench
===================================

// Module: ch446q_matrix_rx
// PURPOSE
//  Clocked receiver for the CH446Q-style serial crosspoint stream (DAT/SK/STB) driven by the HIDman MCU.
//  Holds the 8x5 ZX keyboard switch matrix plus the three special keys (MAGIC/RESET/PAUSE).
//  Answers the ZX keyboard row read: A[15:8] row select -> D[4:0] column data.
//  Sits directly downstream of the MCU pins and upstream of the ZX bus data mux and NMI/RST/BSRQ drivers.
// PARAMETERS
//  SYNC_STAGES  2  synchronizer depth for DAT/SK/STB (>=2)
//  ROWS         8  matrix rows, X address 0..7 = A8..A15
//  COLS         5  matrix columns, Y address 0..4 = D0..D4
// PORTS
//  CLK        in   1   system clock; >= 4x the fastest SK/STB toggle rate
//  RST        in   1   async active-high reset
//  DAT        in   1   async serial address bit / switch state
//  SK         in   1   async shift clock; rising edge shifts DAT in
//  STB        in   1   async strobe; rising edge commits DAT as switch state
//  CLR        in   1   sync clear of all switches (CH446Q RST equivalent)
//  A          in   8   Z80 A[15:8], active-low row select
//  KB_D       out  5   column data, active-low (1 = released)
//  MAGIC      out  1   special switch X=8,Y=5, active-high level (-> NMI)
//  RESET_KEY  out  1   special switch X=8,Y=6, active-high level (-> RST_OUT)
//  PAUSE      out  1   special switch X=8,Y=7, active-high level (-> BSRQ)
//  ADDR_ERR   out  1   1-cycle pulse: rejected commit
//  MATRIX     out  40  flattened switch state, bit X*5+Y, debug only
// BEHAVIOUR
//  - Reset (RST=1): shift reg=0, bit count=0, all switches=0, synchronizers=0.
//    Outputs: KB_D=5'b11111, MAGIC/RESET_KEY/PAUSE=0, ADDR_ERR=0, MATRIX=0.
//  - Inputs pass through SYNC_STAGES flops; edge detect compares last two stages.
//    Input-edge to action latency = SYNC_STAGES+1 CLK.
//  - SK rise: shreg[6:0] <= {shreg[5:0], DAT_s}; bit count saturates at 7.
//    Bits arrive MSB first: Y[2:0] then X[3:0], so shreg = {Y,X}.
//  - STB rise: state = DAT_s; the MCU holds DAT stable >= SYNC_STAGES+1 CLK before STB.
//    Sets the bit count to 0. Writes land one CLK after the detected edge.
//    - count<7: no write, ADDR_ERR pulse.
//    - Y<5, X<8: sw[X][Y] <= state.
//    - X==8, Y in 5..7: corresponding special <= state.
//    - anything else: no write, ADDR_ERR pulse.
//  - SK and STB rise in the same CLK: commit uses the pre-shift shreg.
//    The shift still occurs and the count becomes 1.
//  - CLR=1: all switches and specials <= 0, bit count <= 0, shreg kept.
//    Overrides a same-cycle commit; no ADDR_ERR in that cycle.
//  - STB held high: no repeat commit until it falls and rises again. SK while STB high shifts normally.
//  - Read: KB_D[c] = ~|{ sw[r][c] & ~A[r] for r=0..7 }. Combinational from registers.
//    Multiple low A bits AND the selected rows; A=8'hFF gives 5'b11111.
//  - Specials are registered levels with no debounce; the MCU times the pulse.
//  - RST asserted mid-frame discards the partial frame; the next frame needs 7 fresh bits.
// STRUCTURE
//  - Package zx_kbd_pkg: ROWS, COLS, X_SPECIAL=4'd8, Y_MAGIC=3'd5, Y_RESET=3'd6, Y_PAUSE=3'd7.
//    Also typedef kb_addr_t {logic [2:0] y; logic [3:0] x;}.
//  - Sub-module sync_rise: SYNC_STAGES synchronizer plus rising-edge pulse.
//    Three instances: DAT level only, SK edge, STB edge.
//  - Top holds shreg, bit counter, commit decode, switch regs and the read AND-tree.
// TESTING
//  1. Reset -> KB_D=5'b11111 for A=8'hFE and 8'h7F; MAGIC/RESET_KEY/PAUSE=0.
//  2. Frame Y=0,X=0,state=1; A=8'hFE -> 5'b11110.
//     Frame Y=4,X=4,state=1; A=8'hEF -> 5'b01111.
//     Rewrite Y=0,X=0 with state=0 -> A=8'hFE back to 5'b11111.
//  3. sw[6][2]=1, sw[7][1]=1; A=8'h3F -> 5'b11001.
//     A=8'h7F -> 5'b11101. A=8'hBF -> 5'b11011.
//  4. Frame Y=5,X=8,1 -> MAGIC=1 within SYNC_STAGES+2 CLK of STB.
//     Same for Y=6 -> RESET_KEY, Y=7 -> PAUSE.
//     Frame Y=3,X=8 -> ADDR_ERR one-cycle pulse; no state change.
//  5. Only 5 SK bits then STB -> ADDR_ERR pulse, MATRIX unchanged.
//     A following full 7-bit frame commits normally.
//  6. Set several switches, pulse CLR in the same CLK as a detected STB rise:
//     MATRIX=0, KB_D=5'b11111, specials 0, no ADDR_ERR.
//     Then RST mid-frame (3 bits sent), then a full frame -> that frame commits correctly.

Source files
------------

// File: rtl/zx_kbd_pkg.sv
// Shared constants and address payload for the CH446Q-style ZX keyboard matrix receiver.
package zx_kbd_pkg;

  localparam int unsigned ROWS       = 8;
  localparam int unsigned COLS       = 5;
  localparam int unsigned FRAME_BITS = 7;

  localparam logic [3:0] X_SPECIAL = 4'd8;
  localparam logic [2:0] Y_MAGIC   = 3'd5;
  localparam logic [2:0] Y_RESET   = 3'd6;
  localparam logic [2:0] Y_PAUSE   = 3'd7;

  // Serial address as it sits in the shift register: Y arrives first, so it ends up on top.
  typedef struct packed {
    logic [2:0] y;
    logic [3:0] x;
  } kb_addr_t;

endpackage

// File: rtl/sync_rise.sv
// Multi-flop synchronizer for an asynchronous input, with a rising-edge pulse
// taken between the last synchronizer stage and one history flop.
module sync_rise #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise_c
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              hist_q, hist_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    hist_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign level  = sync_q[STAGES-1];
  assign rise_c = sync_q[STAGES-1] & ~hist_q;

endmodule

// File: rtl/ch446q_matrix_rx.sv
// Receives the MCU's DAT/SK/STB crosspoint stream, holds the 8x5 ZX key matrix
// plus three special keys, and answers the Z80 keyboard row read.
module ch446q_matrix_rx
  import zx_kbd_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 DAT,
  input  logic                 SK,
  input  logic                 STB,
  input  logic                 CLR,
  input  logic [ROWS-1:0]      A,
  output logic [COLS-1:0]      KB_D,
  output logic                 MAGIC,
  output logic                 RESET_KEY,
  output logic                 PAUSE,
  output logic                 ADDR_ERR,
  output logic [ROWS*COLS-1:0] MATRIX
);

  logic dat_s, dat_rise_unused, sk_rise, stb_rise;
  logic unused_sk_level, unused_stb_level;

  sync_rise #(.STAGES(SYNC_STAGES)) u_sync_dat (
    .clk(CLK), .rst(RST), .d(DAT), .level(dat_s), .rise_c(dat_rise_unused));
  sync_rise #(.STAGES(SYNC_STAGES)) u_sync_sk (
    .clk(CLK), .rst(RST), .d(SK), .level(unused_sk_level), .rise_c(sk_rise));
  sync_rise #(.STAGES(SYNC_STAGES)) u_sync_stb (
    .clk(CLK), .rst(RST), .d(STB), .level(unused_stb_level), .rise_c(stb_rise));

  logic [FRAME_BITS-1:0]      shreg_q, shreg_d;
  logic [2:0]                 cnt_q, cnt_d;
  logic [ROWS-1:0][COLS-1:0]  sw_q, sw_d;
  logic                       magic_q, magic_d;
  logic                       reset_key_q, reset_key_d;
  logic                       pause_q, pause_d;
  logic                       addr_err_q, addr_err_d;
  kb_addr_t                   addr;

  assign addr = kb_addr_t'(shreg_q);

  // Shift, commit decode and clear; commit reads shreg_q so a same-cycle shift cannot disturb it.
  always_comb begin
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    sw_d        = sw_q;
    magic_d     = magic_q;
    reset_key_d = reset_key_q;
    pause_d     = pause_q;
    addr_err_d  = 1'b0;

    if (stb_rise) begin
      cnt_d = 3'd0;
      if (cnt_q != 3'(FRAME_BITS)) begin
        addr_err_d = 1'b1;
      end else if (32'(addr.y) < COLS && 32'(addr.x) < ROWS) begin
        sw_d[addr.x[2:0]][addr.y] = dat_s;
      end else if (addr.x == X_SPECIAL && addr.y == Y_MAGIC) begin
        magic_d = dat_s;
      end else if (addr.x == X_SPECIAL && addr.y == Y_RESET) begin
        reset_key_d = dat_s;
      end else if (addr.x == X_SPECIAL && addr.y == Y_PAUSE) begin
        pause_d = dat_s;
      end else begin
        addr_err_d = 1'b1;
      end
    end

    if (sk_rise) begin
      shreg_d = {shreg_q[FRAME_BITS-2:0], dat_s};
      if (stb_rise) begin
        cnt_d = 3'd1;
      end else if (cnt_q != 3'(FRAME_BITS)) begin
        cnt_d = cnt_q + 3'd1;
      end
    end

    if (CLR) begin
      sw_d        = '0;
      magic_d     = 1'b0;
      reset_key_d = 1'b0;
      pause_d     = 1'b0;
      cnt_d       = 3'd0;
      addr_err_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shreg_q     <= '0;
      cnt_q       <= 3'd0;
      sw_q        <= '0;
      magic_q     <= 1'b0;
      reset_key_q <= 1'b0;
      pause_q     <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      sw_q        <= sw_d;
      magic_q     <= magic_d;
      reset_key_q <= reset_key_d;
      pause_q     <= pause_d;
      addr_err_q  <= addr_err_d;
    end
  end

  // Row read: a column goes low if any selected (low) row has that switch closed.
  logic [COLS-1:0][ROWS-1:0] hit;

  for (genvar c = 0; c < COLS; c++) begin : g_col
    for (genvar r = 0; r < ROWS; r++) begin : g_row
      assign hit[c][r] = sw_q[r][c] & ~A[r];
    end
    assign KB_D[c] = ~|hit[c];
  end

  assign MAGIC     = magic_q;
  assign RESET_KEY = reset_key_q;
  assign PAUSE     = pause_q;
  assign ADDR_ERR  = addr_err_q;
  assign MATRIX    = sw_q;

endmodule

// File: tb/tb_ch446q_matrix_rx.sv
// Randomized self-checking bench for ch446q_matrix_rx against a frame-level model.
module tb_ch446q_matrix_rx;

  localparam int unsigned SYNC_STAGES = 2;

  logic        clk = 1'b0;
  logic        rst, dat, sk, stb, clr;
  logic [7:0]  a;
  logic [4:0]  kb_d;
  logic        magic, reset_key, pause, addr_err;
  logic [39:0] matrix;

  ch446q_matrix_rx #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .CLK(clk), .RST(rst), .DAT(dat), .SK(sk), .STB(stb), .CLR(clr), .A(a),
    .KB_D(kb_d), .MAGIC(magic), .RESET_KEY(reset_key), .PAUSE(pause),
    .ADDR_ERR(addr_err), .MATRIX(matrix));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int err_seen = 0;
  int err_exp  = 0;

  // Model: switch array, special levels, and the bits shifted since the last commit.
  bit m_sw[8][5];
  bit m_sp[3];
  int bits_q[$];

  always @(negedge clk) if (addr_err === 1'b1) err_seen++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [39:0] m_matrix();
    logic [39:0] v = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 5; c++)
        if (m_sw[r][c]) v = v | (40'd1 << (r * 5 + c));
    return v;
  endfunction

  function automatic logic [4:0] m_kb(input logic [7:0] av);
    logic [4:0] e = 5'h1F;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 5; c++)
        if (((av >> r) & 8'h1) == 8'h0 && m_sw[r][c]) e = e & ~(5'd1 << c);
    return e;
  endfunction

  task automatic m_clear();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 5; c++) m_sw[r][c] = 1'b0;
    for (int s = 0; s < 3; s++) m_sp[s] = 1'b0;
    bits_q.delete();
  endtask

  // Commit uses the newest seven bits: Y (3, MSB first) then X (4, MSB first).
  task automatic m_commit(input bit state);
    int n, x, y;
    n = bits_q.size();
    if (n < 7) begin
      err_exp++;
    end else begin
      y = bits_q[n-7] * 4 + bits_q[n-6] * 2 + bits_q[n-5];
      x = bits_q[n-4] * 8 + bits_q[n-3] * 4 + bits_q[n-2] * 2 + bits_q[n-1];
      if (y < 5 && x < 8)        m_sw[x][y] = state;
      else if (x == 8 && y >= 5) m_sp[y-5] = state;
      else                       err_exp++;
    end
    bits_q.delete();
  endtask

  task automatic check_state(input string tag);
    logic [7:0] ra;
    ra = 8'($urandom);
    check({tag, ".mtx"},   64'(matrix),    64'(m_matrix()));
    check({tag, ".magic"}, 64'(magic),     64'(m_sp[0]));
    check({tag, ".rstk"},  64'(reset_key), 64'(m_sp[1]));
    check({tag, ".pause"}, 64'(pause),     64'(m_sp[2]));
    check({tag, ".aerr"},  64'(err_seen),  64'(err_exp));
    a = ra;    #1 check({tag, ".kb_rnd"}, 64'(kb_d), 64'(m_kb(ra)));
    a = 8'hFE; #1 check({tag, ".kb_fe"},  64'(kb_d), 64'(m_kb(8'hFE)));
    a = 8'h7F; #1 check({tag, ".kb_7f"},  64'(kb_d), 64'(m_kb(8'h7F)));
  endtask

  task automatic send_bit(input bit b);
    dat = b;
    bits_q.push_back(int'(b));
    tick(2);
    sk = 1'b1;
    tick(3);
    sk = 1'b0;
    tick(3);
  endtask

  // Strobe with DAT=state; optionally raise SK in the very same instant.
  task automatic strobe(input string tag, input bit state, input bit with_sk);
    dat = state;
    tick(SYNC_STAGES + 2);
    stb = 1'b1;
    if (with_sk) sk = 1'b1;
    m_commit(state);
    if (with_sk) bits_q.push_back(int'(state));
    tick(SYNC_STAGES + 2);
    check_state(tag);
    stb = 1'b0;
    sk  = 1'b0;
    tick(4);
  endtask

  task automatic send_addr(input int y, input int x);
    for (int i = 2; i >= 0; i--) send_bit(bit'((y >> i) & 1));
    for (int i = 3; i >= 0; i--) send_bit(bit'((x >> i) & 1));
  endtask

  task automatic frame(input string tag, input int y, input int x, input bit state);
    send_addr(y, x);
    strobe(tag, state, 1'b0);
  endtask

  initial begin
    rst = 1'b1; dat = 1'b0; sk = 1'b0; stb = 1'b0; clr = 1'b0; a = 8'hFF;
    m_clear();
    tick(3);
    check("rst.kb_fe",  64'(kb_d), 64'h1F);
    a = 8'h7F; #1;
    check("rst.kb_7f",  64'(kb_d), 64'h1F);
    check("rst.spec",   64'({magic, reset_key, pause}), 64'h0);
    check("rst.mtx",    64'(matrix), 64'h0);
    rst = 1'b0;
    tick(2);
    check_state("rst");

    frame("f00", 0, 0, 1'b1);
    a = 8'hFE; #1 check("f00.lit", 64'(kb_d), 64'h1E);
    frame("f44", 4, 4, 1'b1);
    a = 8'hEF; #1 check("f44.lit", 64'(kb_d), 64'h0F);
    frame("f00c", 0, 0, 1'b0);
    a = 8'hFE; #1 check("f00c.lit", 64'(kb_d), 64'h1F);

    frame("f62", 2, 6, 1'b1);
    frame("f71", 1, 7, 1'b1);
    a = 8'h3F; #1 check("rows67.lit", 64'(kb_d), 64'h19);
    a = 8'h7F; #1 check("row7.lit",   64'(kb_d), 64'h1D);
    a = 8'hBF; #1 check("row6.lit",   64'(kb_d), 64'h1B);

    frame("magic", 5, 8, 1'b1);
    frame("rstk",  6, 8, 1'b1);
    frame("pause", 7, 8, 1'b1);
    frame("badsp", 3, 8, 1'b1);
    frame("badx",  0, 9, 1'b1);
    frame("magic0", 5, 8, 1'b0);

    for (int i = 0; i < 5; i++) send_bit(bit'($urandom_range(0, 1)));
    strobe("short5", 1'b1, 1'b0);
    frame("aftshort", 3, 2, 1'b1);

    // SK and STB together: old frame commits, new frame starts with one bit.
    send_addr(2, 3);
    strobe("simul", 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) send_bit(bit'((6'b000101 >> (5 - i)) & 1));
    strobe("simul2", 1'b1, 1'b0);

    // CLR lands in the same clock as the detected STB rise.
    send_addr(1, 2);
    dat = 1'b1;
    tick(SYNC_STAGES + 2);
    stb = 1'b1;
    tick(SYNC_STAGES);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    m_clear();
    tick(3);
    check_state("clr");
    check("clr.mtx0", 64'(matrix), 64'h0);
    stb = 1'b0;
    tick(4);

    frame("preR", 3, 3, 1'b1);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    m_clear();
    tick(4);
    check_state("midrst");
    frame("postR", 2, 5, 1'b1);

    for (int it = 0; it < 50; it++) begin
      int kind;
      kind = int'($urandom_range(0, 7));
      if (kind == 0) begin
        for (int i = 0; i < int'($urandom_range(0, 6)); i++) send_bit(bit'($urandom_range(0, 1)));
        strobe("rnd.short", bit'($urandom_range(0, 1)), 1'b0);
      end else if (kind == 1) begin
        send_addr(int'($urandom_range(0, 7)), int'($urandom_range(0, 9)));
        strobe("rnd.simul", bit'($urandom_range(0, 1)), 1'b1);
      end else begin
        frame("rnd", int'($urandom_range(0, 7)), int'($urandom_range(0, 9)),
              bit'($urandom_range(0, 1)));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
